clk_div_multi: RTL and testbench

Parametrised multi-channel clock-enable generator. It replaces single fixed-ratio toggling dividers in lab designs. Each of N_CH channels divides the system clock by a runtime-programmable divisor and provides both a one-cycle `tick` strobe and a 50 % duty `clk_out` square wave. Downstream counters, scanners and debouncers consume `tick` as a clock enable; `clk_out` drives LEDs and other visible-rate logic.

---
 rtl/clk_div_pkg.sv | 8 +
 rtl/clk_div_chan.sv | 46 ++++
 rtl/clk_div_multi.sv | 30 +++
 tb/tb_clk_div_multi.sv | 92 +++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared defaults and width helper for the multi-channel clock divider
package clk_div_pkg;
  localparam int DEF_CNT_W = 32;
  localparam int DEF_DIV = 50_000_000;
  function automatic int sel_w(input int n);
    return n <= 1 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan: one divider channel with programmable divisor, tick strobe and 50% square wave
module clk_div_chan import clk_div_pkg::*; #(
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             tick,
  output logic             clk_out
);
  logic [CNT_W-1:0] div_q, cnt, d;
  logic term;
  // a zero divisor behaves as one; counts at or past the end are terminal so a shrink never wraps
  always_comb begin
    d = div_q == '0 ? CNT_W'(1) : div_q;
    term = cnt >= d - CNT_W'(1);
  end
  // clear beats load beats counting; clear still lets a simultaneous load write the divisor
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q <= CNT_W'(DEFAULT_DIV);
      cnt <= '0;
      tick <= 1'b0;
      clk_out <= 1'b0;
    end else if (clr) begin
      if (load) div_q <= load_val;
      cnt <= '0;
      tick <= 1'b0;
      clk_out <= 1'b0;
    end else if (load) begin
      div_q <= load_val;
      cnt <= '0;
      tick <= 1'b0;
    end else if (en) begin
      cnt <= term ? '0 : cnt + CNT_W'(1);
      tick <= term;
      clk_out <= clk_out ^ term;
    end else begin
      tick <= 1'b0;
    end
  end
endmodule

// File: rtl/clk_div_multi.sv
// clk_div_multi: N_CH independent clock-enable generators with per-channel divisor writes
module clk_div_multi import clk_div_pkg::*; #(
  parameter int N_CH = 4,
  parameter int CNT_W = DEF_CNT_W,
  parameter int DEFAULT_DIV = DEF_DIV
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_CH-1:0]           en,
  input  logic                      sync_clr,
  input  logic                      div_load,
  input  logic [sel_w(N_CH)-1:0]    div_sel,
  input  logic [CNT_W-1:0]          div_val,
  output logic [N_CH-1:0]           tick,
  output logic [N_CH-1:0]           clk_out
);
  localparam int SW = sel_w(N_CH);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    clk_div_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
      .clk(clk),
      .rst(rst),
      .en(en[i]),
      .clr(sync_clr),
      .load(div_load && div_sel == SW'(i)),
      .load_val(div_val),
      .tick(tick[i]),
      .clk_out(clk_out[i])
    );
  end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: randomized check of two divider instances against a period-counting model
module tb_clk_div_multi;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sync_clr = 1'b0;
  logic [4:0] en = '0;
  logic ld_a = 1'b0, ld_b = 1'b0;
  logic [0:0] sel_a = '0;
  logic [1:0] sel_b = '0;
  logic [7:0] div_val = '0;
  logic [1:0] tick_a, co_a;
  logic [2:0] tick_b, co_b;
  int n_vec = 0, n_bad = 0;
  int m_div[5], m_el[5], m_tick[5], m_co[5];

  always #5 clk = ~clk;

  clk_div_multi #(.N_CH(2), .CNT_W(8), .DEFAULT_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .en(en[1:0]), .sync_clr(sync_clr), .div_load(ld_a),
    .div_sel(sel_a), .div_val(div_val), .tick(tick_a), .clk_out(co_a)
  );

  clk_div_multi #(.N_CH(3), .CNT_W(8), .DEFAULT_DIV(4)) dut_b (
    .clk(clk), .rst(rst), .en(en[4:2]), .sync_clr(sync_clr), .div_load(ld_b),
    .div_sel(sel_b), .div_val(div_val), .tick(tick_b), .clk_out(co_b)
  );

  task automatic chk(input string tag, input int cyc, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // model: count enabled edges elapsed in the current period; a period ends after D of them
  task automatic step(input int base, input int n, input bit r, input bit clr, input bit ld,
                      input int sel, input int val, input bit [2:0] e);
    for (int k = 0; k < n; k++) begin
      int i, dd;
      i = base + k;
      if (r) begin
        m_div[i] = 4; m_el[i] = 0; m_tick[i] = 0; m_co[i] = 0;
      end else if (clr) begin
        if (ld && sel == k) m_div[i] = val;
        m_el[i] = 0; m_tick[i] = 0; m_co[i] = 0;
      end else if (ld && sel == k) begin
        m_div[i] = val; m_el[i] = 0; m_tick[i] = 0;
      end else if (e[k]) begin
        dd = m_div[i] == 0 ? 1 : m_div[i];
        m_el[i]++;
        m_tick[i] = m_el[i] >= dd ? 1 : 0;
        if (m_tick[i] == 1) begin
          m_el[i] = 0;
          m_co[i] = 1 - m_co[i];
        end
      end else begin
        m_tick[i] = 0;
      end
    end
  endtask

  function automatic int pack(input int base, input int n, input bit co);
    int v = 0;
    for (int k = 0; k < n; k++) v |= (co ? m_co[base + k] : m_tick[base + k]) << k;
    return v;
  endfunction

  initial begin
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = c < 3 || $urandom_range(0, 199) == 0;
      sync_clr = $urandom_range(0, 59) == 0;
      ld_a = $urandom_range(0, 14) == 0;
      ld_b = $urandom_range(0, 14) == 0;
      sel_a = 1'($urandom_range(0, 1));
      sel_b = 2'($urandom_range(0, 3));
      div_val = 8'($urandom_range(0, 9));
      en = (c < 3) ? 5'b0 : 5'($urandom | $urandom | $urandom);
      @(posedge clk);
      step(0, 2, rst, sync_clr, ld_a, int'(sel_a), int'(div_val), {1'b0, en[1:0]});
      step(2, 3, rst, sync_clr, ld_b, int'(sel_b), int'(div_val), en[4:2]);
      #1;
      chk("a_tick", c, int'(tick_a), pack(0, 2, 1'b0));
      chk("a_clk_out", c, int'(co_a), pack(0, 2, 1'b1));
      chk("b_tick", c, int'(tick_b), pack(2, 3, 1'b0));
      chk("b_clk_out", c, int'(co_b), pack(2, 3, 1'b1));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
